// File: rtl/cpu_core_p.sv
// Parametrised single-clock accumulator CPU core: two-beat fetch, eight-opcode ISA, accumulator datapath.
// Optional feature macro CPU_READY_EN adds the `ready` port for wait-state memories.
module cpu_core_p #(
   parameter int DW = 8,
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic          reset,
`ifdef CPU_READY_EN
   input  logic          ready,
`endif
   inout  wire  [DW-1:0] data,
   output logic [AW-1:0] addr,
   output logic          rd,
   output logic          wr,
   output logic          halt,
   output logic          fetch,
   output logic [2:0]    opcode,
   output logic [AW-1:0] ir_addr,
   output logic [AW-1:0] pc_addr,
   output logic [DW-1:0] acc
);

   typedef enum logic [2:0] {
      S_FETCH_HI, S_FETCH_LO, S_DECODE, S_EXEC_RD, S_EXEC_WR, S_HALTED
   } state_t;

   typedef enum logic [2:0] {
      OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
   } op_t;

   state_t          state;
   state_t          state_nx;
   logic [2*DW-1:0] ir;
   logic [AW-1:0]   pc;
   logic [AW-1:0]   operand;
   op_t             op;
   logic            beat_ready;
   logic            zero;
   logic            drive;
   logic [DW-1:0]   alu_res;
   logic            unused_ir;

   if (AW > 2*DW-3) begin : g_bad_param
      $error("cpu_core_p: AW must not exceed 2*DW-3");
   end

`ifdef CPU_READY_EN
   assign beat_ready = ready;
`else
   assign beat_ready = 1'b1;
`endif

   assign op        = op_t'(ir[2*DW-1 -: 3]);
   assign operand   = ir[AW-1:0];
   assign zero      = (acc == '0);
   assign unused_ir = ^ir;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH_HI;
      else        state <= state_nx;
   end

   // NOTE: every variable gets a default first, so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH_HI: if (beat_ready) state_nx = S_FETCH_LO;
         S_FETCH_LO: if (beat_ready) state_nx = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_HLT:         state_nx = S_HALTED;
               OP_SKZ, OP_JMP: state_nx = S_FETCH_HI;
               OP_STO:         state_nx = S_EXEC_WR;
               default:        state_nx = S_EXEC_RD;
            endcase
         end
         S_EXEC_RD, S_EXEC_WR: if (beat_ready) state_nx = S_FETCH_HI;
         S_HALTED:   state_nx = S_HALTED;
         default:    state_nx = S_FETCH_HI;
      endcase
   end

   always_comb begin
      case (op)
         OP_ADD:  alu_res = acc + data;
         OP_AND:  alu_res = acc & data;
         OP_XOR:  alu_res = acc ^ data;
         default: alu_res = data;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc  <= '0;
         ir  <= '0;
         acc <= '0;
      end else begin
         case (state)
            S_FETCH_HI: if (beat_ready) begin
               ir[2*DW-1:DW] <= data;
               pc            <= pc + AW'(1);
            end
            S_FETCH_LO: if (beat_ready) begin
               ir[DW-1:0] <= data;
               pc         <= pc + AW'(1);
            end
            S_DECODE: begin
               if (op == OP_SKZ && zero) pc <= pc + AW'(2);
               else if (op == OP_JMP)    pc <= operand;
            end
            S_EXEC_RD: if (beat_ready) acc <= alu_res;
            default: ;
         endcase
      end
   end

   // Strobes are gated by reset so they drop the instant reset asserts, not at the next edge.
   always_comb begin
      rd    = 1'b0;
      wr    = 1'b0;
      fetch = 1'b0;
      halt  = 1'b0;
      drive = 1'b0;
      addr  = operand;
      case (state)
         S_FETCH_HI, S_FETCH_LO: begin
            rd    = 1'b1;
            fetch = 1'b1;
            addr  = pc;
         end
         S_EXEC_RD: rd = 1'b1;
         S_EXEC_WR: begin
            wr    = 1'b1;
            drive = 1'b1;
         end
         S_HALTED:  halt = 1'b1;
         default: ;
      endcase
      if (!reset) begin
         rd    = 1'b0;
         wr    = 1'b0;
         fetch = 1'b0;
         halt  = 1'b0;
         drive = 1'b0;
      end
   end

   assign data    = drive ? acc : {DW{1'bz}};
   assign opcode  = ir[2*DW-1 -: 3];
   assign ir_addr = operand;
   assign pc_addr = pc;

endmodule
